// File: rtl/jtcps1_line_sched_if.sv
// Handshake bundle between the CPS1 line scheduler, the timing block and the layer engines.
interface jtcps1_line_sched_if;
    logic       start;
    logic [7:0] vrender;
    logic       VB;
    logic [3:0] layer_en;
    logic [3:0] eng_done;
    logic       clr;
    logic [3:0] eng_go;
    logic [3:0] eng_abort;
    logic [7:0] line;
    logic [1:0] active;
    logic       busy;
    logic       line_done;
    logic [7:0] overrun_cnt;
    logic [3:0] tout_flags;

    modport master (
        output start, vrender, VB, layer_en, eng_done, clr,
        input  eng_go, eng_abort, line, active, busy, line_done, overrun_cnt, tout_flags
    );

    modport slave (
        input  start, vrender, VB, layer_en, eng_done, clr,
        output eng_go, eng_abort, line, active, busy, line_done, overrun_cnt, tout_flags
    );
endinterface

// File: rtl/jtcps1_line_sched.sv
// Per-line render scheduler: launches the enabled layer engines one at a time,
// steers the shared tile-ROM mux and aborts engines that hang or overrun the line.
module jtcps1_line_sched #(
    parameter int TOUT_W  = 10,
    parameter bit SKIP_VB = 1'b1
) (
    input  logic                rst,
    input  logic                clk,
    jtcps1_line_sched_if.slave  sched
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, NEXT} state_t;

    state_t            r_state, w_state_next;
    logic              r_start_l;
    logic              r_pend, w_pend_next;
    logic [7:0]        r_line;
    logic [3:0]        r_en_l;
    logic [1:0]        r_idx, w_idx_next;
    logic [1:0]        r_active;
    logic [TOUT_W-1:0] r_wdog;
    logic [3:0]        r_tout;
    logic [7:0]        r_ovr;

    logic       w_st_rise, w_accept, w_busy, w_done, w_expired, w_ovr_inc;
    logic [3:0] w_go, w_abort, w_tout_set, w_above;
    logic       w_line_done;

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign w_st_rise = sched.start & ~r_start_l;
    assign w_accept  = w_st_rise & ~(SKIP_VB & sched.VB);
    assign w_busy    = (r_state != IDLE);
    assign w_done    = sched.eng_done[r_idx];
    assign w_expired = &r_wdog;
    assign w_above   = r_en_l & (4'b1110 << r_idx);

    // r_pend marks the decode cycle after a start was captured, once en_l is valid
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_pend_next  = 1'b0;
        w_go         = 4'b0000;
        w_abort      = 4'b0000;
        w_tout_set   = 4'b0000;
        w_line_done  = 1'b0;
        w_ovr_inc    = 1'b0;
        if (w_st_rise && w_busy) begin
            w_ovr_inc    = 1'b1;
            w_state_next = IDLE;
            w_pend_next  = w_accept;
            if (r_state == WAIT)
                w_abort = 4'b0001 << r_idx;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_pend) begin
                        if (r_en_l == 4'b0000) begin
                            w_line_done = 1'b1;
                        end else begin
                            w_idx_next   = f_lowest(r_en_l);
                            w_state_next = LAUNCH;
                        end
                    end else if (w_accept) begin
                        w_pend_next = 1'b1;
                    end
                end
                LAUNCH: begin
                    w_go         = 4'b0001 << r_idx;
                    w_state_next = WAIT;
                end
                WAIT: begin
                    if (w_done) begin
                        w_state_next = NEXT;
                    end else if (w_expired) begin
                        w_abort      = 4'b0001 << r_idx;
                        w_tout_set   = 4'b0001 << r_idx;
                        w_state_next = NEXT;
                    end
                end
                default: begin
                    if (w_above != 4'b0000) begin
                        w_idx_next   = f_lowest(w_above);
                        w_state_next = LAUNCH;
                    end else begin
                        w_line_done  = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_start_l <= 1'b0;
            r_pend    <= 1'b0;
            r_line    <= 8'd0;
            r_en_l    <= 4'd0;
            r_idx     <= 2'd0;
            r_active  <= 2'd0;
            r_wdog    <= '0;
            r_tout    <= 4'd0;
            r_ovr     <= 8'd0;
        end else begin
            r_state   <= w_state_next;
            r_start_l <= sched.start;
            r_pend    <= w_pend_next;
            r_idx     <= w_idx_next;
            if (w_pend_next) begin
                r_line <= sched.vrender;
                r_en_l <= sched.layer_en;
            end
            // active changes together with the go pulse and then holds
            if (w_state_next == LAUNCH)
                r_active <= w_idx_next;
            if (r_state == LAUNCH)
                r_wdog <= '0;
            else if (r_state == WAIT)
                r_wdog <= r_wdog + 1'b1;
            if (sched.clr)
                r_tout <= 4'd0;
            else
                r_tout <= r_tout | w_tout_set;
            if (sched.clr)
                r_ovr <= 8'd0;
            else if (w_ovr_inc && r_ovr != 8'hFF)
                r_ovr <= r_ovr + 8'd1;
        end
    end

    assign sched.eng_go      = w_go;
    assign sched.eng_abort   = w_abort;
    assign sched.line        = r_line;
    assign sched.active      = r_active;
    assign sched.busy        = w_busy;
    assign sched.line_done   = w_line_done;
    assign sched.overrun_cnt = r_ovr;
    assign sched.tout_flags  = r_tout;
endmodule

// File: doc/jtcps1_line_sched.md
Name: jtcps1_line_sched

Overview:
- Per-line render scheduler for the CPS1 video pipeline.
- On each line-start strobe from the timing generator, latches the render line number.
- Launches the enabled layer engines (scroll1, scroll2, scroll3, objects) one at a time with a go/done handshake, and drives the shared tile-ROM mux select.
- Detects engines that overrun the line budget or hang, aborts them and reports the faults to the debug/status registers.

Parameters:
- TOUT_W, 10, width of the per-engine watchdog counter; timeout fires after 2**TOUT_W-1 clk cycles in WAIT.
- SKIP_VB, 1, when 1 no sequence starts while VB is high.

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  system clock
- start  in  1  line-start strobe from timing block; may stay high several clk cycles; only its rising edge is used
- vrender  in  8  line to render, sampled on the start rising edge
- VB  in  1  vertical blank
- layer_en  in  4  engine enable mask, bit0=scr1, bit1=scr2, bit2=scr3, bit3=obj; sampled on the start rising edge
- eng_done  in  4  per-engine completion pulses
- clr  in  1  synchronous clear of tout_flags and overrun_cnt
- eng_go  out  4  one-hot, one-clk launch pulse
- eng_abort  out  4  one-hot, one-clk abort pulse
- line  out  8  latched render line
- active  out  2  index of the engine owning the ROM port
- busy  out  1  high in any state except IDLE
- line_done  out  1  one-clk pulse when the sequence for a line completes
- overrun_cnt  out  8  count of lines whose sequence was cut by a new start; saturates at 255
- tout_flags  out  4  sticky per-engine watchdog flags

Behaviour:
- Reset values: all outputs 0; state IDLE; start edge register 0; watchdog counter 0.
- Edge detect: st_rise = start & ~start_l, where start_l is registered every clk.
- States: IDLE, LAUNCH, WAIT, NEXT.
- IDLE:
  - Action only on st_rise. If SKIP_VB and VB, ignore it.
  - Otherwise latch line<=vrender and en_l<=layer_en.
  - If en_l==0, pulse line_done next clk and stay IDLE.
  - Else idx <= lowest set bit of en_l; go to LAUNCH.
- LAUNCH (1 clk):
  - eng_go[idx]=1, active<=idx, watchdog<=0; go to WAIT.
  - active is updated in the same clk as the go pulse and holds until the next LAUNCH. It does not return to 0 in IDLE.
- WAIT:
  - Watchdog increments every clk.
  - eng_done[idx] -> NEXT.
  - Watchdog reaching all-ones -> tout_flags[idx]<=1, eng_abort[idx] pulse, NEXT.
  - If done and timeout coincide, done wins: no flag, no abort.
  - eng_done bits other than idx are ignored in every state.
- NEXT (1 clk):
  - If a set bit of en_l exists above idx, idx<=that bit and go to LAUNCH.
  - Else line_done pulse and go to IDLE.
- Overrun: st_rise while busy, in any state, has priority over all other transitions.
  - eng_abort[idx] pulses only if state is WAIT.
  - overrun_cnt increments with saturation.
  - The new line is then handled exactly as in IDLE: SKIP_VB check, latch, go to LAUNCH or return to IDLE.
  - No line_done pulse for the aborted line.
- Simultaneous events:
  - st_rise and eng_done in the same clk: overrun path taken; the done is discarded.
  - clr and an overrun increment in the same clk: clr wins, so the result is 0. Same for clr and a timeout flag set.
- Latency: st_rise to first eng_go = 2 clk (edge register + LAUNCH). eng_done to next eng_go = 2 clk (NEXT + LAUNCH).
- Asynchronous reset mid-sequence returns to IDLE immediately. No abort pulse is generated.

Test Plan:
- layer_en=4'b1111, vrender=8'h20, engines answer done 5 clk after go -> go pulses in order bit0,1,2,3; active 0,1,2,3; line=8'h20; one line_done; overrun_cnt=0.
- layer_en=4'b1010 -> go only on bits 1 and 3; first go 2 clk after the start edge.
- VB=1, SKIP_VB=1, start pulses -> no go, busy stays 0. Repeat with layer_en=0 and VB=0 -> line_done only.
- Engine 2 never answers, TOUT_W=4 -> eng_abort[2] after 15 clk in WAIT; tout_flags=4'b0100; engine 3 then launches. clr clears tout_flags.
- New start edge while engine 1 is in WAIT -> eng_abort[1]; overrun_cnt=1; sequence restarts from bit0 with the new line. 300 consecutive overruns -> overrun_cnt=255.
- eng_done[1] in the same clk as the watchdog expiry -> no flag, no abort. Spurious eng_done[3] while idx=0 -> ignored. Reset asserted in WAIT -> all outputs 0.
